// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: default widths, fixed PC
// values and the next-PC source encoding.
package mips_pkg;

    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_RAS_DEPTH = 4;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_0020;

    typedef enum logic [2:0] {
        SRC_SEQ,
        SRC_BR,
        SRC_JMP,
        SRC_JR,
        SRC_EXC,
        SRC_HOLD
    } pc_src_e;

    // Every source other than sequential and hold changes the fetch stream.
    function automatic logic is_redirect(input pc_src_e src);
        return (src == SRC_BR) || (src == SRC_JMP) ||
               (src == SRC_JR) || (src == SRC_EXC);
    endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack with saturating count; pushing onto a
// full stack silently replaces the oldest entry and flags it.
module ras_stack #(
    parameter int unsigned W = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         clear_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] push_data_i,
    output logic [W-1:0] top_o,
    output logic         valid_o,
    output logic         overflow_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             ovf_q;
    logic             ovf_d;

    // ptr_q names the newest entry; a push lands one slot above it.
    assign wr_ptr = ptr_q + PTR_W'(1);
    assign top_o = mem_q[ptr_q];
    assign valid_o = (cnt_q != '0);
    assign overflow_o = ovf_q;

    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        ovf_d = 1'b0;
        if (push_i) begin
            ptr_d = wr_ptr;
            if (cnt_q == FULL) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (pop_i && valid_o) begin
            ptr_d = ptr_q - PTR_W'(1);
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr] <= push_data_i;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Registered program counter with prioritised next-PC selection, stall
// support and a return-address stack used to check JR targets.
module pc_sequencer
    import mips_pkg::*;
#(
    parameter int unsigned       ADDR_W     = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(DEF_RESET_PC),
    parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(DEF_EXC_VECTOR),
    parameter int unsigned       RAS_DEPTH  = DEF_RAS_DEPTH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic              exception,
    input  logic              jal,
    input  logic              jump,
    input  logic              jr,
    input  logic              branchTaken,
    input  logic [ADDR_W-1:0] jumpAdress,
    input  logic [ADDR_W-1:0] jumpRegister,
    input  logic [ADDR_W-1:0] branchAdress,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] linkAdress,
    output logic              redirect,
    output logic [ADDR_W-1:0] rasTop,
    output logic              rasValid,
    output logic              rasMismatch,
    output logic              rasOverflow
);

    pc_src_e           src;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic              redir_q;
    logic              redir_d;
    logic              mism_q;
    logic              mism_d;
    logic              push;
    logic              pop;

    assign pc = pc_q;
    assign linkAdress = pc_q + ADDR_W'(1);
    assign redirect = redir_q;
    assign rasMismatch = mism_q;

    always_comb begin
        src = SRC_SEQ;
        if (exception) begin
            src = SRC_EXC;
        end else if (stall) begin
            src = SRC_HOLD;
        end else if (jr) begin
            src = SRC_JR;
        end else if (jal || jump) begin
            src = SRC_JMP;
        end else if (branchTaken) begin
            src = SRC_BR;
        end
    end

    always_comb begin
        pc_d = linkAdress;
        unique case (src)
            SRC_EXC:  pc_d = EXC_VECTOR;
            SRC_HOLD: pc_d = pc_q;
            SRC_JR:   pc_d = jumpRegister;
            SRC_JMP:  pc_d = jumpAdress;
            SRC_BR:   pc_d = branchAdress;
            SRC_SEQ:  pc_d = linkAdress;
            default:  pc_d = linkAdress;
        endcase
    end

    // Stack only moves for the source actually chosen, and never under reset.
    assign push = !reset && (src == SRC_JMP) && jal;
    assign pop = !reset && (src == SRC_JR);
    assign redir_d = is_redirect(src);
    assign mism_d = pop && (!rasValid || (rasTop != jumpRegister));

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            redir_q <= 1'b0;
            mism_q  <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            redir_q <= redir_d;
            mism_q  <= mism_d;
        end
    end

    ras_stack #(
        .W     (ADDR_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk_i       (clock),
        .clear_i     (reset),
        .push_i      (push),
        .pop_i       (pop),
        .push_data_i (linkAdress),
        .top_o       (rasTop),
        .valid_o     (rasValid),
        .overflow_o  (rasOverflow)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: the driver queues hand-computed
// expectations, a monitor compares them after every clock edge.
module tb_pc_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        exception = 1'b0;
    logic        jal = 1'b0;
    logic        jump = 1'b0;
    logic        jr = 1'b0;
    logic        branchTaken = 1'b0;
    logic [31:0] jumpAdress = '0;
    logic [31:0] jumpRegister = '0;
    logic [31:0] branchAdress = '0;
    logic [31:0] pc;
    logic [31:0] linkAdress;
    logic        redirect;
    logic [31:0] rasTop;
    logic        rasValid;
    logic        rasMismatch;
    logic        rasOverflow;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] pc;
        logic        rd;
        logic        rv;
        logic        mm;
        logic        ov;
        logic        tc;
        logic [31:0] top;
    } exp_t;

    exp_t exp_q[$];

    // ctl bits: {reset, stall, exception, jal, jump, jr, branchTaken}
    localparam logic [6:0] N  = 7'b0000000;
    localparam logic [6:0] R  = 7'b1000000;
    localparam logic [6:0] S  = 7'b0100000;
    localparam logic [6:0] E  = 7'b0010000;
    localparam logic [6:0] JL = 7'b0001000;
    localparam logic [6:0] J  = 7'b0000100;
    localparam logic [6:0] JR = 7'b0000010;
    localparam logic [6:0] B  = 7'b0000001;

    pc_sequencer dut (
        .clock        (clock),
        .reset        (reset),
        .stall        (stall),
        .exception    (exception),
        .jal          (jal),
        .jump         (jump),
        .jr           (jr),
        .branchTaken  (branchTaken),
        .jumpAdress   (jumpAdress),
        .jumpRegister (jumpRegister),
        .branchAdress (branchAdress),
        .pc           (pc),
        .linkAdress   (linkAdress),
        .redirect     (redirect),
        .rasTop       (rasTop),
        .rasValid     (rasValid),
        .rasMismatch  (rasMismatch),
        .rasOverflow  (rasOverflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want,
                     $time);
        end
    endtask

    task automatic step(input logic [6:0] ctl, input logic [31:0] ja,
                        input logic [31:0] jra, input logic [31:0] ba,
                        input logic [31:0] e_pc, input logic e_rd,
                        input logic e_rv, input logic e_mm,
                        input logic e_ov, input logic e_tc,
                        input logic [31:0] e_top);
        exp_t e;
        @(negedge clock);
        {reset, stall, exception, jal, jump, jr, branchTaken} = ctl;
        jumpAdress = ja;
        jumpRegister = jra;
        branchAdress = ba;
        e.pc = e_pc;
        e.rd = e_rd;
        e.rv = e_rv;
        e.mm = e_mm;
        e.ov = e_ov;
        e.tc = e_tc;
        e.top = e_top;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pc", pc, e.pc);
                chk("linkAdress", linkAdress, e.pc + 32'd1);
                chk("redirect", 32'(redirect), 32'(e.rd));
                chk("rasValid", 32'(rasValid), 32'(e.rv));
                chk("rasMismatch", 32'(rasMismatch), 32'(e.mm));
                chk("rasOverflow", 32'(rasOverflow), 32'(e.ov));
                if (e.tc) chk("rasTop", rasTop, e.top);
            end
        end
    end

    initial begin : driver
        step(R, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 7; i++)
            step(N, 0, 0, 0, 32'(i), 0, 0, 0, 0, 0, 0);
        step(B,  0,  0, 40,  40, 1, 0, 0, 0, 0, 0);
        step(N,  0,  0,  0,  41, 0, 0, 0, 0, 0, 0);
        step(J,  9,  0,  0,   9, 1, 0, 0, 0, 0, 0);
        step(N,  0,  0,  0,  10, 0, 0, 0, 0, 0, 0);
        step(JL, 100, 0, 0, 100, 1, 1, 0, 0, 1, 11);
        step(N,  0,  0,  0, 101, 0, 1, 0, 0, 1, 11);
        step(JR, 0, 11,  0,  11, 1, 0, 0, 0, 0, 0);
        step(N,  0,  0,  0,  12, 0, 0, 0, 0, 0, 0);
        step(J,  1,  0,  0,   1, 1, 0, 0, 0, 0, 0);
        step(JL, 100, 0, 0, 100, 1, 1, 0, 0, 1, 2);
        step(N,  0,  0,  0, 101, 0, 1, 0, 0, 1, 2);
        step(JL, 200, 0, 0, 200, 1, 1, 0, 0, 1, 102);
        step(N,  0,  0,  0, 201, 0, 1, 0, 0, 1, 102);
        step(JL, 300, 0, 0, 300, 1, 1, 0, 0, 1, 202);
        step(N,  0,  0,  0, 301, 0, 1, 0, 0, 1, 202);
        step(JL, 400, 0, 0, 400, 1, 1, 0, 0, 1, 302);
        step(N,  0,  0,  0, 401, 0, 1, 0, 0, 1, 302);
        step(JL, 500, 0, 0, 500, 1, 1, 0, 1, 1, 402);
        step(N,  0,  0,  0, 501, 0, 1, 0, 0, 1, 402);
        step(JR, 0, 402, 0, 402, 1, 1, 0, 0, 1, 302);
        step(JR, 0, 302, 0, 302, 1, 1, 0, 0, 1, 202);
        step(JR, 0, 202, 0, 202, 1, 1, 0, 0, 1, 102);
        step(JR, 0, 102, 0, 102, 1, 0, 0, 0, 0, 0);
        step(JR, 0,  7,  0,   7, 1, 0, 1, 0, 0, 0);
        step(N,  0,  0,  0,   8, 0, 0, 0, 0, 0, 0);
        step(JL, 50, 0,  0,  50, 1, 1, 0, 0, 1, 9);
        step(JR, 0, 77,  0,  77, 1, 0, 1, 0, 0, 0);
        step(N,  0,  0,  0,  78, 0, 0, 0, 0, 0, 0);
        step(JL | B, 300, 0, 60, 300, 1, 1, 0, 0, 1, 79);
        step(JR | JL, 999, 79, 0, 79, 1, 0, 0, 0, 0, 0);
        step(J | B, 3, 0, 6,   3, 1, 0, 0, 0, 0, 0);
        step(S | J, 50, 0, 0,  3, 0, 0, 0, 0, 0, 0);
        step(S | E | J, 50, 0, 0, 32, 1, 0, 0, 0, 0, 0);
        step(S | JL, 70, 0, 0, 32, 0, 0, 0, 0, 0, 0);
        step(S | B, 0, 0, 90,  32, 0, 0, 0, 0, 0, 0);
        step(N,  0,  0,  0,  33, 0, 0, 0, 0, 0, 0);
        step(J, 32'hFFFF_FFFF, 0, 0, 32'hFFFF_FFFF, 1, 0, 0, 0, 0, 0);
        step(N,  0,  0,  0,   0, 0, 0, 0, 0, 0, 0);
        step(N,  0,  0,  0,   1, 0, 0, 0, 0, 0, 0);
        step(JL, 100, 0, 0, 100, 1, 1, 0, 0, 1, 2);
        step(JL, 200, 0, 0, 200, 1, 1, 0, 0, 1, 101);
        step(R | JL, 300, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(N,  0,  0,  0,   1, 0, 0, 0, 0, 0, 0);
        step(JL, 10, 0,  0,  10, 1, 1, 0, 0, 1, 2);
        step(E | JR, 0, 55, 0, 32, 1, 1, 0, 0, 1, 2);
        @(negedge clock);
        {reset, stall, exception, jal, jump, jr, branchTaken} = N;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clock);
            #3;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, expected 0",
                     exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Registered program-counter unit for the word-addressed MIPS core; successor to the combinational next-PC adder. Holds the PC, selects the next PC by fixed priority (exception, JR, J/JAL, taken branch, sequential), supports pipeline stall, and keeps a parametrised return-address stack (RAS) that is pushed on JAL and checked on JR. Sits between the control unit/branch comparator and the instruction memory address port.

Parameters:
ADDR_W, 32, PC and target width in bits (word address, increment is 1)
RESET_PC, 0, PC value loaded on reset
EXC_VECTOR, 32'h0000_0020, PC loaded on exception (truncated to ADDR_W)
RAS_DEPTH, 4, return-address stack entries (power of two, >=2)

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high
stall  input  1  hold PC; ignore all redirects except exception
exception  input  1  redirect to EXC_VECTOR
jal  input  1  jump-and-link this cycle
jump  input  1  plain jump this cycle
jr  input  1  jump-register this cycle
branchTaken  input  1  resolved conditional branch taken
jumpAdress  input  ADDR_W  target for jump/jal
jumpRegister  input  ADDR_W  target for jr
branchAdress  input  ADDR_W  target for taken branch
pc  output  ADDR_W  current PC (registered)
linkAdress  output  ADDR_W  pc+1, combinational, for $ra write
redirect  output  1  registered; 1 for one cycle after a non-sequential PC load
rasTop  output  ADDR_W  top-of-stack entry (combinational from stack)
rasValid  output  1  stack non-empty
rasMismatch  output  1  registered pulse: jr popped and rasTop != jumpRegister
rasOverflow  output  1  registered pulse: push onto full stack

Behaviour:
- Reset (synchronous, clock edge with reset=1): pc=RESET_PC, stack count=0, pointer=0, redirect=0, rasMismatch=0, rasOverflow=0. Reset overrides every other input.
- Next-PC priority each edge (reset=0):
  1. exception -> EXC_VECTOR, regardless of stall; no RAS action.
  2. stall -> pc holds; jal/jr/jump/branch ignored, no RAS action.
  3. jr -> jumpRegister.
  4. jal or jump -> jumpAdress (jal also pushes).
  5. branchTaken -> branchAdress.
  6. otherwise pc+1 (modulo 2^ADDR_W; all-ones wraps to 0).
- Multiple controls asserted: only highest priority takes effect; jal push happens only when jal is the selected source.
- redirect=1 on the cycle after cases 1, 3, 4, 5 were selected; 0 otherwise (including stall).
- Latency: new pc visible one cycle after control inputs sampled; linkAdress follows pc combinationally.
- RAS: circular buffer of RAS_DEPTH entries, pointer plus count (0..RAS_DEPTH).
  - Push (jal selected): write pc+1 at top, count+1. If count==RAS_DEPTH, overwrite oldest, count stays saturated, rasOverflow pulses.
  - Pop (jr selected): compare rasTop with jumpRegister; unequal -> rasMismatch pulses; count-1. Target always jumpRegister (RAS is a check, not a predictor).
  - Pop on empty: no count change, rasMismatch pulses.
  - rasTop undefined-but-stable when rasValid=0; bench must not check it.
- Reset mid-operation clears stack; entries need not be zeroed.

Decomposition:
- Shared package mips_pkg: ADDR_W default, RESET_PC, EXC_VECTOR, next-PC source enum (SRC_SEQ, SRC_BR, SRC_JMP, SRC_JR, SRC_EXC, SRC_HOLD).
- One sub-module: ras_stack (push, pop, top, valid, overflow, clear), parametrised by width and depth; priority mux and PC register stay in pc_sequencer.

Test Plan:
- Reset, then 5 idle cycles -> pc 0,1,2,3,4,5; redirect=0 throughout; rasValid=0.
- At pc=7: branchTaken=1, branchAdress=40 -> pc=40 next cycle, redirect=1 one cycle, then 41.
- At pc=10: jal=1, jumpAdress=100 -> pc=100, rasTop=11, rasValid=1; later jr=1, jumpRegister=11 -> pc=11, rasMismatch=0, rasValid=0.
- Five jals (DEPTH=4) from pcs 1,101,201,301,401 -> rasOverflow on 5th; pops return 402,302,202,102 then pop on empty gives rasMismatch=1.
- stall=1 with jump=1, jumpAdress=50 at pc=3 -> pc stays 3, no redirect; same cycle exception=1 -> pc=32 (EXC_VECTOR), redirect=1.
- pc=all-ones sequential -> pc=0; reset asserted mid-JAL chain -> pc=RESET_PC, rasValid=0 next cycle.
